wt_seq_operand_accumulator: RTL and testbench

- Sequential counterpart to the combinational 4-operand Wallace-tree adders.
- Accepts operands one per beat over a valid/ready stream and accumulates them.
- After NUM_OPS beats, presents the sum together with the packed operand set, so the result can be cross-checked against the parallel tree.
- Sits between a serial operand source and the tree / checker logic.

---
 rtl/wt_seq_operand_accumulator.sv | 89 ++++++++
 tb/tb_wt_seq_operand_accumulator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wt_seq_operand_accumulator.sv
// rtl/wt_seq_operand_accumulator.sv - serial operand accumulator feeding the Wallace-tree cross-check
// Collects NUM_OPS operands one per beat, then holds the sum and the packed operand set until taken.
module wt_seq_operand_accumulator #(
    parameter int WIDTH     = 4,
    parameter int NUM_OPS   = 4,
    parameter int OUT_WIDTH = 6
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           OPERAND,
    input  logic                       OP_VALID,
    output logic                       OP_READY,
    output logic [OUT_WIDTH-1:0]       RESULT,
    output logic [NUM_OPS*WIDTH-1:0]   OPS_PACKED,
    output logic                       RES_VALID,
    input  logic                       RES_READY,
    output logic                       BUSY
);

    localparam int CW = $clog2(NUM_OPS + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_OPS - 1);

    typedef enum logic {
        S_COLLECT,
        S_HOLD
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              count_q, count_d;
    logic [OUT_WIDTH-1:0]       acc_q, acc_d;
    logic [OUT_WIDTH-1:0]       result_q, result_d;
    logic [NUM_OPS*WIDTH-1:0]   ops_q, ops_d;
    logic [OUT_WIDTH-1:0]       sum;

    assign sum = acc_q + OUT_WIDTH'(OPERAND);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_COLLECT;
            count_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ops_q    <= ops_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        result_d = result_q;
        ops_d    = ops_q;
        case (state_q)
            S_COLLECT: begin
                if (OP_VALID) begin
                    acc_d = sum;
                    ops_d[int'(count_q)*WIDTH +: WIDTH] = OPERAND;
                    count_d = count_q + 1'b1;
                    // Final beat: the result register is loaded on the same edge that enters HOLD.
                    if (count_q == LAST_BEAT) begin
                        state_d  = S_HOLD;
                        result_d = sum;
                    end
                end
            end
            S_HOLD: begin
                if (RES_READY) begin
                    state_d = S_COLLECT;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    assign OP_READY   = (state_q == S_COLLECT);
    assign RES_VALID  = (state_q == S_HOLD);
    assign BUSY       = (count_q != '0) || (state_q == S_HOLD);
    assign RESULT     = result_q;
    assign OPS_PACKED = ops_q;

endmodule

// File: tb/tb_wt_seq_operand_accumulator.sv
// tb/tb_wt_seq_operand_accumulator.sv - self-checking bench for wt_seq_operand_accumulator
module tb_wt_seq_operand_accumulator;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int OW = 6;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [W-1:0]    OPERAND = '0;
    logic            OP_VALID = 1'b0;
    logic            OP_READY;
    logic [OW-1:0]   RESULT;
    logic [N*W-1:0]  OPS_PACKED;
    logic            RES_VALID;
    logic            RES_READY = 1'b0;
    logic            BUSY;

    wt_seq_operand_accumulator #(.WIDTH(W), .NUM_OPS(N), .OUT_WIDTH(OW)) dut (
        .CLK(CLK), .RST(RST), .OPERAND(OPERAND), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
        .RESULT(RESULT), .OPS_PACKED(OPS_PACKED), .RES_VALID(RES_VALID),
        .RES_READY(RES_READY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a group is a list of received operands; the result is their plain sum.
    int unsigned m_grp[$];
    int unsigned m_slot[N];
    int unsigned m_result = 0;
    bit          m_hold = 0;
    bit          m_live = 0;
    int          cycle = 0;
    int          hs_cycle[$];
    int unsigned hs_value[$];

    always @(posedge CLK) begin
        cycle++;
        if (!RST && RES_VALID && RES_READY) begin
            hs_cycle.push_back(cycle);
            hs_value.push_back(RESULT);
        end
        if (RST) begin
            m_grp.delete();
            foreach (m_slot[k]) m_slot[k] = 0;
            m_result = 0;
            m_hold = 0;
            m_live = 1;
        end else if (m_live) begin
            if (!m_hold) begin
                if (OP_VALID) begin
                    m_slot[m_grp.size()] = OPERAND;
                    m_grp.push_back(OPERAND);
                    if (m_grp.size() == N) begin
                        m_result = 0;
                        foreach (m_grp[k]) m_result += m_grp[k];
                        m_hold = 1;
                    end
                end
            end else if (RES_READY) begin
                m_hold = 0;
                m_grp.delete();
            end
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            logic [N*W-1:0] packed_exp;
            packed_exp = '0;
            for (int k = 0; k < N; k++) packed_exp[k*W +: W] = W'(m_slot[k]);
            check("model_op_ready", OP_READY, !m_hold);
            check("model_res_valid", RES_VALID, m_hold);
            check("model_result", RESULT, m_result);
            check("model_ops_packed", OPS_PACKED, packed_exp);
            check("model_busy", BUSY, (m_grp.size() != 0) || m_hold);
        end
    end

    // Driver works on negedges; on return from send the handshake edge has just passed.
    task automatic send(input int v);
        int n = 0;
        OP_VALID = 1'b1;
        OPERAND  = W'(v);
        while (!OP_READY) begin
            @(negedge CLK);
            n++;
            if (n > 50) begin
                check("send_timeout", 1, 0);
                break;
            end
        end
        @(negedge CLK);
        OP_VALID = 1'b0;
    endtask

    task automatic take_result();
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
    endtask

    initial begin
        int c0;
        int unsigned held_res;
        repeat (2) @(negedge CLK);
        check("reset_result", RESULT, 0);
        check("reset_ops", OPS_PACKED, 0);
        check("reset_res_valid", RES_VALID, 0);
        check("reset_busy", BUSY, 0);
        check("reset_op_ready", OP_READY, 1);
        RST = 1'b0;

        // Basic group
        send(1); send(2); send(3); send(4);
        check("basic_valid_next_cycle", RES_VALID, 1);
        check("basic_result", RESULT, 10);
        check("basic_ops", OPS_PACKED, 16'h4321);
        take_result();
        check("basic_ready_back", OP_READY, 1);

        // Maximum values
        repeat (4) send(15);
        check("max_result", RESULT, 60);
        check("max_ops", OPS_PACKED, 16'hFFFF);
        take_result();

        // Input gaps
        send(7);
        check("gap_busy_first_beat", BUSY, 1);
        repeat (3) begin OPERAND = W'($urandom); @(negedge CLK); end
        send(0); send(9);
        OPERAND = W'($urandom); @(negedge CLK);
        send(2);
        check("gap_result", RESULT, 18);
        check("gap_ops", OPS_PACKED, 16'h2907);

        // Output backpressure with operand toggling while held
        held_res = RESULT;
        OP_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            OPERAND = W'($urandom);
            @(negedge CLK);
            check("bp_valid", RES_VALID, 1);
            check("bp_result", RESULT, held_res);
            check("bp_op_ready", OP_READY, 0);
        end
        OP_VALID = 1'b0;
        take_result();
        check("bp_ready_after_release", OP_READY, 1);

        // Reset mid-group
        send(5); send(5);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_result", RESULT, 0);
        check("midrst_ops", OPS_PACKED, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_op_ready", OP_READY, 1);
        repeat (4) send(1);
        check("midrst_new_result", RESULT, 4);
        take_result();

        // Back-to-back groups with sink always ready
        hs_cycle.delete();
        hs_value.delete();
        RES_READY = 1'b1;
        repeat (4) send(2);
        repeat (4) send(3);
        c0 = 0;
        while (hs_cycle.size() < 2 && c0 < 20) begin @(negedge CLK); c0++; end
        RES_READY = 1'b0;
        if (hs_cycle.size() >= 2) begin
            check("b2b_first", hs_value[0], 8);
            check("b2b_second", hs_value[1], 12);
            check("b2b_period", hs_cycle[1] - hs_cycle[0], 5);
        end else begin
            check("b2b_handshakes", hs_cycle.size(), 2);
        end

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            OP_VALID  = ($urandom_range(0, 3) != 0);
            OPERAND   = W'($urandom);
            RES_READY = ($urandom_range(0, 2) != 0);
            RST       = ($urandom_range(0, 99) == 0);
            @(negedge CLK);
        end
        RST = 1'b0;
        OP_VALID = 1'b0;
        RES_READY = 1'b0;
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
